// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the instruction-memory loader.
//   state_t        - loader FSM encoding
//   BYTES_PER_INST - UART bytes per instruction at the default widths
//   HALT_INST      - end-of-program marker at the default 32-bit width
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int INST_SZ_DFLT   = 32;
  localparam int BYTE_SZ_DFLT   = 8;
  localparam int BYTES_PER_INST = INST_SZ_DFLT / BYTE_SZ_DFLT;

  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// byte_assembler: shifts UART bytes into an instruction word, first byte
// ending up in the MSBs.
//   i_clk, i_reset  - clock, asynchronous active-low reset
//   i_clear         - discard any partial word (wins over a byte)
//   i_accept        - bytes are only taken while the loader wants them
//   i_rx_done/data  - received byte strobe and payload
//   o_word          - word as it would be after taking the current byte
//   o_word_ready    - current byte completes a word (combinational, one cycle)
module byte_assembler
  import loader_pkg::*;
#(
  parameter int INST_SZ = 32,
  parameter int BYTE_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic               i_rx_done,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  output logic [INST_SZ-1:0] o_word,
  output logic               o_word_ready
);

  localparam int NB = INST_SZ / BYTE_SZ;
  localparam int CW = $clog2(NB + 1);

  logic [INST_SZ-1:0] shift_q;
  logic [CW-1:0]      cnt_q;
  logic               take;

  assign take         = i_rx_done & i_accept & ~i_clear;
  assign o_word_ready = take && (cnt_q == CW'(NB - 1));
  // Word is exposed one byte early so the owner can register it on the
  // same edge that samples the final byte.
  assign o_word       = {shift_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (i_clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (take) begin
      shift_q <= o_word;
      cnt_q   <= o_word_ready ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a program received over UART into instruction memory.
// Bytes are assembled big-endian into instructions, each written with a
// one-cycle strobe at sequential word addresses. The pipeline is held off
// (o_enable=0) while loading; loading ends on the all-ones HALT word or
// when the last address has been written.
//   i_clk, i_reset   - clock, asynchronous active-low reset
//   i_start          - begin / restart a load from address 0
//   i_rx_done/data   - received byte strobe and payload
//   o_write          - instruction write strobe
//   o_instruction    - written word; holds between writes
//   o_addr           - word address of the write
//   o_enable         - pipeline enable (low while loading)
//   o_busy           - loading in progress
//   o_done           - load finished
//   o_overflow       - memory filled without seeing HALT
//   o_word_cnt       - words written in this load
module instr_loader
  import loader_pkg::*;
#(
  parameter int INST_SZ = 32,
  parameter int BYTE_SZ = 8,
  parameter int MEM_SZ  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_rx_done,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [MEM_SZ-1:0]  o_addr,
  output logic               o_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [MEM_SZ:0]    o_word_cnt
);

  // All-ones at any width; equals HALT_INST at the default width.
  localparam logic [INST_SZ-1:0] HALT = {INST_SZ{1'b1}};

  state_t             state_q, state_d;
  logic [INST_SZ-1:0] word;
  logic               word_ready;
  logic               accept;
  logic               is_halt;
  logic               last_addr;

  assign is_halt   = (o_instruction == HALT);
  assign last_addr = (o_addr == {MEM_SZ{1'b1}});
  // In WRITE a byte belongs to the next word only if loading continues.
  assign accept    = (state_q == RECV) ||
                     ((state_q == WRITE) && !is_halt && !last_addr);

  byte_assembler #(
    .INST_SZ (INST_SZ),
    .BYTE_SZ (BYTE_SZ)
  ) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_start),
    .i_accept     (accept),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .o_word       (word),
    .o_word_ready (word_ready)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    o_write  = 1'b0;
    o_enable = 1'b1;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = RECV;
      end
      RECV: begin
        o_enable = 1'b0;
        o_busy   = 1'b1;
        if (i_start)         state_d = RECV;
        else if (word_ready) state_d = WRITE;
      end
      WRITE: begin
        o_write  = 1'b1;
        o_enable = 1'b0;
        o_busy   = 1'b1;
        if (i_start)        state_d = RECV;
        else if (is_halt)   state_d = DONE;
        else if (last_addr) state_d = DONE;
        else                state_d = RECV;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) state_d = RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Restart clears counters even if it lands on a WRITE cycle; that
  // write still happens because o_write is driven from the current state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_addr     <= '0;
      o_word_cnt <= '0;
      o_overflow <= 1'b0;
    end else if (i_start) begin
      o_addr     <= '0;
      o_word_cnt <= '0;
      o_overflow <= 1'b0;
    end else if (state_q == WRITE) begin
      o_word_cnt <= o_word_cnt + 1'b1;
      if (!is_halt && last_addr) o_overflow <= 1'b1;
      if (!is_halt && !last_addr) o_addr <= o_addr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                               o_instruction <= '0;
    else if ((state_q == RECV) && word_ready)   o_instruction <= word;
  end

endmodule
